// File: rtl/irrigation_scheduler_if.sv
// Request/fault inputs and valve/pump/status outputs of the irrigation scheduler.
interface irrigation_scheduler_if;
    logic [1:0] req1;
    logic [1:0] req2;
    logic       lvl_fault;
    logic [1:0] valve1;
    logic [1:0] valve2;
    logic       pump_on;
    logic [1:0] grant;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output req1, req2, lvl_fault,
        input  valve1, valve2, pump_on, grant, busy, done, err
    );

    modport slave (
        input  req1, req2, lvl_fault,
        output valve1, valve2, pump_on, grant, busy, done, err
    );
endinterface

// File: rtl/irrigation_scheduler.sv
// Time-shares one pump between two irrigation zones: prime, bounded watering slot,
// settle gap, round-robin between zones, and a latched safe shutdown on level faults.
module irrigation_scheduler #(
    parameter int PRIME_CYCLES = 4,
    parameter int SLOT_CYCLES  = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int CLEAR_CYCLES = 8
) (
    input  logic clk,
    input  logic reset,
    irrigation_scheduler_if.slave bus
);

    localparam int M1    = (PRIME_CYCLES > SLOT_CYCLES) ? PRIME_CYCLES : SLOT_CYCLES;
    localparam int M2    = (GAP_CYCLES > CLEAR_CYCLES) ? GAP_CYCLES : CLEAR_CYCLES;
    localparam int CNT_W = $clog2(((M1 > M2) ? M1 : M2) + 1);

    localparam logic [CNT_W-1:0] PRIME_END = CNT_W'(PRIME_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_WARN = CNT_W'(SLOT_CYCLES - 2);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_END = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, PRIME, WATER, GAP, FAULT} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             sel, sel_n;     // 0 = zone 1, 1 = zone 2
    logic             last, last_n;   // zone served most recently
    logic [1:0]       mask, mask_n;
    logic             done_n;
    logic             win;
    logic             any_req;
    logic [1:0]       req_sel, req_win;

    always_comb begin
        any_req = (bus.req1 != 2'b00) || (bus.req2 != 2'b00);
        if ((bus.req1 != 2'b00) && (bus.req2 != 2'b00)) win = ~last;
        else if (bus.req2 != 2'b00)                      win = 1'b1;
        else                                             win = 1'b0;
        req_sel = sel ? bus.req2 : bus.req1;
        req_win = win ? bus.req2 : bus.req1;
    end

    // done is raised one edge ahead so the pulse lands on the final WATER cycle.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        sel_n   = sel;
        last_n  = last;
        mask_n  = mask;
        done_n  = 1'b0;
        if (bus.lvl_fault) begin
            state_n = FAULT;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (any_req) begin
                        state_n = PRIME;
                        sel_n   = win;
                    end
                end
                PRIME: begin
                    if (cnt == PRIME_END) begin
                        state_n = WATER;
                        cnt_n   = '0;
                        mask_n  = req_sel;
                        last_n  = sel;
                    end
                end
                WATER: begin
                    if (bus.done) begin
                        state_n = GAP;
                        cnt_n   = '0;
                    end else if ((cnt == SLOT_WARN) || (req_sel == 2'b00)) begin
                        done_n = 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt_n = '0;
                        if (any_req) begin
                            state_n = WATER;
                            sel_n   = win;
                            last_n  = win;
                            mask_n  = req_win;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                FAULT: begin
                    if (cnt == CLEAR_END) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sel         <= 1'b0;
            last        <= 1'b1;
            mask        <= 2'b00;
            bus.valve1  <= 2'b00;
            bus.valve2  <= 2'b00;
            bus.pump_on <= 1'b0;
            bus.grant   <= 2'b00;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sel         <= sel_n;
            last        <= last_n;
            mask        <= mask_n;
            bus.valve1  <= (state_n == WATER && !sel_n) ? mask_n : 2'b00;
            bus.valve2  <= (state_n == WATER &&  sel_n) ? mask_n : 2'b00;
            bus.pump_on <= (state_n == PRIME) || (state_n == WATER) || (state_n == GAP);
            bus.grant   <= ((state_n == PRIME) || (state_n == WATER)) ?
                           (sel_n ? 2'b10 : 2'b01) : 2'b00;
            bus.busy    <= (state_n != IDLE);
            bus.done    <= done_n;
            bus.err     <= (state_n == FAULT);
        end
    end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Time-shares a single pump/water supply between two irrigation zones; only one zone's valves open at a time.
- Each zone presents a 2-bit valve-request mask: 01 = valve A, 10 = valve B, 11 = both, 00 = idle.
- Sequence per service: prime the pump, water for a bounded slot, then close valves for a settle gap.
- Round-robin arbitration between zones; immediate safe shutdown on a water-level fault.
- Sits between the zone request inputs and the valve/pump drivers, downstream of the level-monitor logic.

Parameters:
PRIME_CYCLES, 4, cycles pump runs with all valves closed before the first slot
SLOT_CYCLES, 16, maximum watering cycles per grant
GAP_CYCLES, 2, cycles with valves closed between consecutive slots (pump stays on)
CLEAR_CYCLES, 8, consecutive fault-free cycles required to leave FAULT

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req1  in  2  zone 1 valve-request mask
req2  in  2  zone 2 valve-request mask
lvl_fault  in  1  1 = water level out of range (low or overflow)
valve1  out  2  zone 1 valve drive (bit0 = A, bit1 = B)
valve2  out  2  zone 2 valve drive
pump_on  out  1  pump enable
grant  out  2  one-hot active zone (01 = zone 1, 10 = zone 2, 00 = none)
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse when a slot ends
err  out  1  high while in FAULT

Behaviour:
- Reset (async) values:
  - state = IDLE; all outputs 0; counters 0.
  - Captured mask = 00.
  - last_served = zone 2, so zone 1 wins the first tie.
- All outputs are registered and decoded from state plus the captured mask.
- States and outputs:
  - IDLE: pump 0, valves 0, grant 00.
  - PRIME: pump 1, valves 0, grant = selected zone.
  - WATER: pump 1, granted zone's valve output = captured mask, other zone's valves 0.
  - GAP: pump 1, valves 0, grant 00.
  - FAULT: pump 0, valves 0, grant 00, err 1.
- Arbitration:
  - Only one requester nonzero: that zone wins.
  - Both nonzero: the zone that is not last_served wins.
  - On entry to WATER, the winner's mask is captured and last_served is updated.
  - A mask change during WATER does not alter the open valves. Exception: a mask of 00 ends the slot early.
- Transitions:
  - IDLE -> PRIME when any request is nonzero; the winner is selected at that edge.
  - PRIME -> WATER after exactly PRIME_CYCLES cycles in PRIME.
  - WATER -> GAP after SLOT_CYCLES cycles, or the cycle after the granted zone's request reads 00. done pulses on the last WATER cycle.
  - GAP, after GAP_CYCLES:
    - Other zone requesting -> WATER for the other zone, with no re-prime.
    - Only the same zone requesting -> WATER for the same zone.
    - No requests -> IDLE.
- Fault handling:
  - lvl_fault = 1 in any state -> FAULT on the next edge. This has priority over every other transition and closes valves and stops the pump that cycle.
  - No done pulse on abort.
  - The clear counter counts consecutive lvl_fault = 0 cycles in FAULT. Any lvl_fault = 1 resets it.
  - On reaching CLEAR_CYCLES -> IDLE. A fresh PRIME is always required after a fault.
- Counters:
  - Width $clog2(max parameter + 1).
  - Cleared on every state entry; no wrap is possible.
- Simultaneous events: fault > slot timeout > early release.
- Reset asserted mid-operation forces the IDLE outputs immediately (asynchronously).

Test Plan:
- req1 = 01 held from reset release -> pump_on rises 1 cycle later; 4 PRIME cycles with valve1 = 00; then valve1 = 01 for exactly 16 cycles; done pulses on cycle 16; 2 GAP cycles; then WATER again for zone 1 with no re-prime.
- req1 = 11 and req2 = 10 asserted together from IDLE -> zone 1 served first (valve1 = 11); after the gap, valve2 = 10 is served; valves never open for both zones in the same cycle.
- During zone 2 WATER at cycle 5, drop req2 to 00 -> slot ends early with a done pulse; with no requests, GAP then IDLE, pump_on = 0.
- lvl_fault pulsed for 1 cycle mid-WATER -> next cycle err = 1, pump and valves 0; a second fault pulse after 3 clear cycles restarts the count; IDLE reached after 8 clean cycles, then a full 4-cycle PRIME precedes any watering.
- lvl_fault = 1 on the same edge as slot timeout -> FAULT entered, no done pulse.
- Reset asserted mid-PRIME between clock edges -> all outputs 0 immediately; after release, round-robin restarts with zone 1 priority.
